// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame width and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRts,
    StStart,
    StData,
    StStop,
    StAck
  } ps2_tx_state_e;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Deglitch filter for the PS/2 clock line with a registered falling-edge strobe.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_raw,
  output logic ps2c_filt,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic                  filt_q, filt_d;
  logic                  filt_prev_q;

  // Shift in the raw line; the filtered value only moves on a unanimous window.
  always_comb begin
    sr_d   = {ps2c_raw, sr_q[FILTER_LEN-1:1]};
    filt_d = filt_q;
    if (&sr_q) begin
      filt_d = 1'b1;
    end else if (sr_q == '0) begin
      filt_d = 1'b0;
    end
  end

  // Filter state; an idle PS/2 clock is high, so reset to all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      sr_q        <= sr_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign ps2c_filt = filt_q;
  assign fall_edge = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, framing, device ACK check, watchdog.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned RTS_CYCLES     = 8192,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic       rx_idle,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       err_ack,
  output logic       err_timeout
);

  localparam int unsigned RtsW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_tx_state_e          state_q, state_d;
  logic [PS2_DATA_BITS:0] sr_q, sr_d;
  logic [RtsW-1:0]        rts_cnt_q, rts_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [WdW-1:0]         wdog_q, wdog_d;
  logic                   c_oe_q, c_oe_d;
  logic                   d_oe_q, d_oe_d;
  logic                   done_q, done_d;
  logic                   err_ack_q, err_ack_d;
  logic                   err_to_q, err_to_d;
  logic                   ps2c_filt;
  logic                   fall_edge;
  logic                   wdog_active;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_raw (ps2c),
    .ps2c_filt(ps2c_filt),
    .fall_edge(fall_edge)
  );

  // Next-state, datapath and registered pin-drive decode.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    rts_cnt_d = rts_cnt_q;
    bit_cnt_d = bit_cnt_q;
    wdog_d    = wdog_q;
    done_d    = 1'b0;
    err_ack_d = err_ack_q;
    err_to_d  = err_to_q;

    case (state_q)
      StIdle: begin
        if (wr_ps2 && rx_idle) begin
          sr_d      = {odd_parity(din), din};
          rts_cnt_d = RtsW'(RTS_CYCLES - 1);
          state_d   = StRts;
        end
      end
      StRts: begin
        wdog_d    = '0;
        err_ack_d = 1'b0;
        err_to_d  = 1'b0;
        if (rts_cnt_q == '0) begin
          state_d = StStart;
        end else begin
          rts_cnt_d = rts_cnt_q - 1'b1;
        end
      end
      StStart: begin
        if (fall_edge) begin
          bit_cnt_d = 4'(PS2_DATA_BITS);
          state_d   = StData;
        end
      end
      StData: begin
        if (fall_edge) begin
          // Counter at zero means the parity bit has already been on the line.
          if (bit_cnt_q == '0) begin
            state_d = StStop;
          end else begin
            sr_d      = {1'b0, sr_q[PS2_DATA_BITS:1]};
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      StStop: begin
        if (fall_edge) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (fall_edge) begin
          err_ack_d = ps2d;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog overrides any edge-driven transition in the same cycle.
    wdog_active = (state_q == StStart) || (state_q == StData) ||
                  (state_q == StStop)  || (state_q == StAck);
    if (wdog_active) begin
      if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
        err_to_d  = 1'b1;
        err_ack_d = err_ack_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end

    c_oe_d = (state_d == StRts);
    d_oe_d = (state_d == StStart) || ((state_d == StData) && !sr_d[0]);
  end

  // State, counters, drive enables and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      rts_cnt_q <= '0;
      bit_cnt_q <= '0;
      wdog_q    <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      done_q    <= 1'b0;
      err_ack_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      rts_cnt_q <= rts_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      wdog_q    <= wdog_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      done_q    <= done_d;
      err_ack_q <= err_ack_d;
      err_to_q  <= err_to_d;
    end
  end

  // Open-collector: only ever pull low or release.
  assign ps2c = c_oe_q ? 1'b0 : 1'bz;
  assign ps2d = d_oe_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == StIdle);
  assign tx_done_tick = done_q;
  assign err_ack      = err_ack_q;
  assign err_timeout  = err_to_q;

endmodule
